// File: rtl/spi_pkg.sv
// spi_pkg: SFR map, SPCR/SPSR bit positions and sequencer state encoding
package spi_pkg;
   localparam logic [7:0] DEF_SPCR_ADDR = 8'h02;
   localparam logic [7:0] DEF_SPSR_ADDR = 8'h03;
   localparam logic [7:0] DEF_SPDR_ADDR = 8'h04;
   localparam int SPE_BIT  = 6;
   localparam int SPIF_BIT = 0;
   localparam int WCOL_BIT = 1;
   localparam logic [7:0] SPE_MASK = 8'h01 << SPE_BIT;
   localparam logic [7:0] CLR_MASK = (8'h01 << SPIF_BIT) | (8'h01 << WCOL_BIT);
   typedef enum logic [3:0] {
      S_IDLE, S_CFG, S_WAIT_TX, S_WR_DR, S_POLL, S_RD_DR, S_RX_HOLD, S_CLR, S_ABORT, S_DONE
   } state_t;
endpackage

// File: rtl/spi_sfr_access.sv
// spi_sfr_access: 2-cycle SETUP/ACCESS engine; SETUP is driven straight from the
// request so a new access can follow an ACCESS cycle with no idle gap.
module spi_sfr_access (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       psel,
   output logic       penable,
   output logic       WE,
   output logic       RE,
   output logic [7:0] ADDRD,
   output logic [7:0] DATABI,
   input  logic [7:0] DATAB
);
   logic       acc, acc_we, setup;
   logic [7:0] addr_q, wdata_q;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc     <= 1'b0;
         acc_we  <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         rdata   <= 8'h00;
      end else begin
         acc <= setup;
         if (setup) begin
            acc_we  <= we;
            addr_q  <= addr;
            wdata_q <= we ? wdata : 8'h00;
         end
         if (setup && !we) rdata <= DATAB;
      end
   end
   always_comb begin
      setup   = req && !acc;
      ack     = acc;
      psel    = setup || acc;
      penable = acc;
      WE      = acc ? acc_we : setup && we;
      RE      = acc ? !acc_we : setup && !we;
      ADDRD   = setup ? addr : addr_q;
      DATABI  = setup ? (we ? wdata : 8'h00) : (acc ? wdata_q : 8'h00);
   end
endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: runs a multi-byte spi_master transaction over its SFR port,
// popping tx bytes and returning received bytes on a valid/ready stream.
module spi_xfer_sequencer
   import spi_pkg::*;
#(
   parameter int         LEN_W     = 8,
   parameter int         TMO_W     = 16,
   parameter logic [7:0] SPCR_ADDR = DEF_SPCR_ADDR,
   parameter logic [7:0] SPSR_ADDR = DEF_SPSR_ADDR,
   parameter logic [7:0] SPDR_ADDR = DEF_SPDR_ADDR
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [7:0]       cfg_spcr,
   input  logic [LEN_W-1:0] xfer_len,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             busy,
   output logic             done,
   output logic             err_tmo,
   output logic             err_wcol,
   output logic             psel,
   output logic             penable,
   output logic             WE,
   output logic             RE,
   output logic [7:0]       ADDRD,
   output logic [7:0]       DATABI,
   input  logic [7:0]       DATAB
);
   localparam logic [TMO_W-1:0] TMO_MAX  = '1;
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
   state_t             state, nxt;
   logic [7:0]         cfg_q, tx_byte, addr, wdata, rdata;
   logic [LEN_W-1:0]   len_q, bcnt;
   logic [TMO_W-1:0]   tmo;
   logic               req, we, ack;
   spi_sfr_access u_sfr (
      .CLK(CLK), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .psel(psel), .penable(penable), .WE(WE), .RE(RE),
      .ADDRD(ADDRD), .DATABI(DATABI), .DATAB(DATAB)
   );
   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else state <= nxt;
   end
   // A timeout is only acted on at an ACCESS boundary so the in-flight poll completes.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = start ? S_CFG : S_IDLE;
         S_CFG:     nxt = ack ? S_WAIT_TX : S_CFG;
         S_WAIT_TX: nxt = tx_valid ? S_WR_DR : S_WAIT_TX;
         S_WR_DR:   nxt = ack ? S_POLL : S_WR_DR;
         S_POLL:    nxt = !ack ? S_POLL : (tmo == TMO_MAX) ? S_ABORT : rdata[SPIF_BIT] ? S_RD_DR : S_POLL;
         S_RD_DR:   nxt = ack ? S_RX_HOLD : S_RD_DR;
         S_RX_HOLD: nxt = rx_ready ? S_CLR : S_RX_HOLD;
         S_CLR:     nxt = !ack ? S_CLR : (bcnt == len_q) ? S_DONE : S_WAIT_TX;
         S_ABORT:   nxt = ack ? S_DONE : S_ABORT;
         default:   nxt = S_IDLE;
      endcase
   end
   always_comb begin
      req      = state inside {S_CFG, S_WR_DR, S_POLL, S_RD_DR, S_CLR, S_ABORT};
      we       = !(state inside {S_POLL, S_RD_DR});
      addr     = (state inside {S_CFG, S_ABORT}) ? SPCR_ADDR : (state inside {S_POLL, S_CLR}) ? SPSR_ADDR : SPDR_ADDR;
      wdata    = state == S_CFG ? cfg_q : state == S_WR_DR ? tx_byte : state == S_CLR ? CLR_MASK :
                 state == S_ABORT ? (cfg_q & ~SPE_MASK) : 8'h00;
      tx_ready = state == S_WAIT_TX && tx_valid;
      rx_valid = state == S_RX_HOLD;
      busy     = state != S_IDLE && state != S_DONE;
      done     = state == S_DONE;
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cfg_q    <= 8'h00;
         len_q    <= '0;
         bcnt     <= '0;
         tx_byte  <= 8'h00;
         rx_data  <= 8'h00;
         tmo      <= '0;
         err_tmo  <= 1'b0;
         err_wcol <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            cfg_q    <= cfg_spcr | SPE_MASK;
            len_q    <= xfer_len;
            bcnt     <= '0;
            err_tmo  <= 1'b0;
            err_wcol <= 1'b0;
         end
         if (tx_ready) tx_byte <= tx_data;
         if (state == S_WR_DR) tmo <= '0;
         if (state == S_POLL) tmo <= tmo + 1'b1;
         if (state == S_POLL && tmo == TMO_LAST) err_tmo <= 1'b1;
         if (state == S_POLL && ack && rdata[WCOL_BIT]) err_wcol <= 1'b1;
         if (state == S_RD_DR && ack) rx_data <= rdata;
         if (state == S_CLR && ack && bcnt != len_q) bcnt <= bcnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: behavioural SFR slave plus expected bus-write / rx-byte
// lists derived per transaction; one negedge process compares everything.
module tb_spi_xfer_sequencer;
   localparam logic [7:0] A_SPCR = 8'h02, A_SPSR = 8'h03, A_SPDR = 8'h04;
   logic CLK = 1'b0, RESET = 1'b1, start = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
   logic [7:0] cfg_spcr = 8'h00, xfer_len = 8'h00, tx_data = 8'h00;
   logic tx_ready, rx_valid, busy, done, err_tmo, err_wcol, psel, penable, WE, RE;
   logic [7:0] rx_data, ADDRD, DATABI, DATAB;
   int checks = 0, failures = 0;
   logic [7:0] tx_q[$], plan[$], exp_rx[$], rx_hist[$];
   logic [15:0] exp_wr[$], wr_hist[$];
   int done_cnt = 0, txr_cnt = 0, poll_cnt = 0;
   bit hold_rx = 1'b0, gaps = 1'b1;
   logic [7:0] s_spcr = 8'h00, s_spsr = 8'h00, s_rx = 8'h00, xmask = 8'h00;
   int s_cnt = -1, s_wcol_cnt = 0, spif_max = 8, wcol_pct = 0;
   bit never_spif = 1'b0, slave_clr = 1'b0;

   always #5 CLK = ~CLK;

   spi_xfer_sequencer #(.LEN_W(8), .TMO_W(6)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .cfg_spcr(cfg_spcr), .xfer_len(xfer_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .done(done), .err_tmo(err_tmo),
      .err_wcol(err_wcol), .psel(psel), .penable(penable), .WE(WE), .RE(RE), .ADDRD(ADDRD),
      .DATABI(DATABI), .DATAB(DATAB)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] outs();
      return {psel, penable, WE, RE, ADDRD, DATABI, rx_data, tx_ready, rx_valid, busy, done, err_tmo, err_wcol};
   endfunction

   // SPI slave stand-in: SPIF rises a random delay after an SPDR write, rx byte is tx^xmask
   assign DATAB = (ADDRD == A_SPSR) ? s_spsr : (ADDRD == A_SPDR) ? s_rx : s_spcr;
   always @(posedge CLK) begin
      if (slave_clr) begin
         s_spsr <= 8'h00;
         s_cnt  <= -1;
      end else begin
         if (s_cnt > 0) s_cnt <= s_cnt - 1;
         else if (s_cnt == 0) begin
            s_spsr[0] <= 1'b1;
            s_cnt     <= -1;
         end
         if (psel && penable && WE) begin
            if (ADDRD == A_SPCR) s_spcr <= DATABI;
            if (ADDRD == A_SPSR) s_spsr <= s_spsr & ~DATABI;
            if (ADDRD == A_SPDR) begin
               s_rx  <= DATABI ^ xmask;
               s_cnt <= never_spif ? -1 : int'($urandom_range(spif_max, 0));
               if (int'($urandom_range(99, 0)) < wcol_pct) begin
                  s_spsr[1]  <= 1'b1;
                  s_wcol_cnt <= s_wcol_cnt + 1;
               end
            end
         end
      end
   end

   initial begin
      bit pop;
      forever begin
         @(negedge CLK);
         pop = tx_ready && tx_valid;
         @(posedge CLK);
         #1;
         if (pop && tx_q.size() > 0) void'(tx_q.pop_front());
         tx_valid = tx_q.size() > 0 && (!gaps || $urandom_range(3, 0) != 0);
         tx_data  = tx_q.size() > 0 ? tx_q[0] : 8'($urandom);
         rx_ready = !hold_rx && $urandom_range(2, 0) != 0;
      end
   end

   logic prev_setup = 1'b0, p_we = 1'b0, prev_hold = 1'b0, prev_err = 1'b0;
   logic [15:0] p_ad = 16'h0, ew;
   logic [7:0] prev_rx = 8'h00;
   logic [8:0] er;
   always @(negedge CLK) begin
      if (RESET) begin
         prev_setup = 1'b0;
         prev_hold  = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (prev_setup) begin
            chk("access_phase", {psel, penable, WE, RE}, {2'b11, p_we, !p_we});
            chk("access_hold", {ADDRD, DATABI}, p_ad);
         end else if (psel) chk("setup_phase", {penable, WE ^ RE}, 2'b01);
         else chk("idle_bus", {penable, WE, RE, DATABI}, 0);
         prev_setup = psel && !penable;
         p_we = WE;
         p_ad = {ADDRD, DATABI};
         if (psel && penable && WE) begin
            wr_hist.push_back({ADDRD, DATABI});
            if (exp_wr.size() > 0) ew = exp_wr.pop_front();
            else ew = 16'h0000;
            chk("bus_write", {ADDRD, DATABI}, ew);
            if (ADDRD == A_SPDR) poll_cnt = 0;
         end
         if (err_tmo && !prev_err) chk("tmo_polls", poll_cnt, 63);
         prev_err = err_tmo;
         if (psel && RE && ADDRD == A_SPSR) poll_cnt++;
         if (prev_hold) chk("rx_stable", {rx_valid, rx_data}, {1'b1, prev_rx});
         if (rx_valid && rx_ready) begin
            rx_hist.push_back(rx_data);
            if (exp_rx.size() > 0) er = {1'b1, exp_rx.pop_front()};
            else er = 9'h000;
            chk("rx_data", {1'b1, rx_data}, er);
         end
         prev_hold = rx_valid && !rx_ready;
         prev_rx = rx_data;
         if (tx_ready) txr_cnt++;
         if (done) begin
            done_cnt++;
            chk("done_busy", busy, 0);
            chk("done_drained", exp_wr.size() + exp_rx.size(), 0);
         end
      end
   end

   task automatic xfer(input logic [7:0] cfg, input logic [7:0] len, input bit tmo_case, input bit hold, input bit poke);
      logic [7:0] b;
      int d0, t0, w0, n_before;
      wr_hist.delete();
      rx_hist.delete();
      exp_wr.push_back({A_SPCR, cfg | 8'h40});
      for (int i = 0; i <= int'(len); i++) begin
         if (plan.size() > 0) b = plan.pop_front();
         else b = 8'($urandom);
         if (!tmo_case || i == 0) begin
            tx_q.push_back(b);
            exp_wr.push_back({A_SPDR, b});
            if (!tmo_case) begin
               exp_wr.push_back({A_SPSR, 8'h03});
               exp_rx.push_back(b ^ xmask);
            end
         end
      end
      if (tmo_case) exp_wr.push_back({A_SPCR, cfg & 8'hBF});
      d0 = done_cnt;
      t0 = txr_cnt;
      w0 = s_wcol_cnt;
      hold_rx = hold;
      @(posedge CLK); #1;
      start = 1'b1; cfg_spcr = cfg; xfer_len = len;
      @(posedge CLK); #1;
      start = 1'b0; cfg_spcr = 8'($urandom); xfer_len = 8'($urandom);
      chk("busy_after_start", busy, 1);
      if (poke) begin
         repeat (6) @(posedge CLK);
         #1 start = 1'b1; cfg_spcr = 8'hFF; xfer_len = 8'h05;
         @(posedge CLK);
         #1 start = 1'b0;
      end
      if (hold) begin
         for (int c = 0; c < 2000 && !rx_valid; c++) begin @(posedge CLK); #1; end
         n_before = exp_wr.size();
         repeat (50) @(posedge CLK);
         #1;
         chk("hold_valid", rx_valid, 1);
         chk("hold_no_clr", exp_wr.size(), n_before);
         hold_rx = 1'b0;
      end
      for (int c = 0; c < 40000 && done_cnt == d0; c++) @(posedge CLK);
      #1;
      chk("done_seen", done_cnt != d0, 1);
      chk("txr_count", txr_cnt - t0, tmo_case ? 1 : int'(len) + 1);
      chk("err_tmo", err_tmo, tmo_case);
      chk("err_wcol", err_wcol, s_wcol_cnt != w0);
      repeat (3) @(posedge CLK);
      #1;
      chk("single_done", done_cnt - d0, 1);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("reset_state", outs(), 0);

      plan = {8'hA5};
      xfer(8'h50, 8'h00, 0, 0, 0);
      chk("lit_spcr", wr_hist[0], 16'h0250);
      chk("lit_spdr", wr_hist[1], 16'h04A5);
      chk("lit_clr", wr_hist[2], 16'h0303);
      chk("lit_rx", rx_hist[0], 8'hA5);

      plan = {8'h01, 8'h02, 8'h03, 8'h04};
      xfer(8'h73, 8'h03, 0, 0, 0);
      chk("lit_spcr4", wr_hist[0], 16'h0273);
      chk("lit_rx4", {rx_hist[0], rx_hist[1], rx_hist[2], rx_hist[3]}, 32'h01020304);

      plan = {8'h3C};
      xfer(8'h51, 8'h00, 0, 1, 0);
      xfer(8'h52, 8'h02, 0, 0, 1);

      wcol_pct = 30;
      for (int i = 0; i < 6; i++) begin
         xmask = 8'($urandom);
         xfer(8'($urandom), 8'($urandom_range(9, 0)), 0, 0, i[0]);
      end
      wcol_pct = 0;
      xmask = 8'h00;

      never_spif = 1'b1;
      plan = {8'h99};
      xfer(8'h13, 8'h04, 1, 0, 0);
      chk("lit_tmo_spcr", wr_hist[0], 16'h0253);
      chk("lit_abort", wr_hist[2], 16'h0213);

      exp_wr.push_back({A_SPCR, 8'h50});
      exp_wr.push_back({A_SPDR, 8'h77});
      tx_q.push_back(8'h77);
      @(posedge CLK); #1;
      start = 1'b1; cfg_spcr = 8'h50; xfer_len = 8'h00;
      @(posedge CLK); #1;
      start = 1'b0;
      for (int c = 0; c < 200 && !(psel && RE && ADDRD == A_SPSR); c++) begin @(posedge CLK); #1; end
      chk("reached_poll", psel && RE && ADDRD == A_SPSR, 1);
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK);
      #1;
      chk("reset_mid_poll", outs(), 0);
      RESET = 1'b0;
      exp_wr.delete();
      exp_rx.delete();
      tx_q.delete();
      slave_clr = 1'b1;
      @(posedge CLK);
      #1 slave_clr = 1'b0;
      never_spif = 1'b0;

      plan = {8'h5A};
      xfer(8'h50, 8'h01, 0, 0, 0);
      chk("lit_after_reset", wr_hist[1], 16'h045A);

      spif_max = 2;
      xfer(8'h50, 8'hFF, 0, 0, 0);
      chk("max_rx_count", rx_hist.size(), 256);
      chk("max_wr_count", wr_hist.size(), 513);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
